// File: rtl/psdi_pkg.sv
// Shared definitions for the ALUX datapath: opcodes, sequencer states and
// register-bank constants used by alux_sequencer and seq_watchdog.
package psdi_pkg;

  localparam int REG_IDX_W = 4;
  localparam int OPR_W     = 4;
  localparam int WDOG_W    = 6;

  // Register-bank write mode selecting a full-word write
  localparam logic [1:0] ENDW_FULL = 2'b00;

  // ALUX opcodes
  localparam logic [OPR_W-1:0] OPR_A   = 4'b0000;
  localparam logic [OPR_W-1:0] OPR_B   = 4'b0001;
  localparam logic [OPR_W-1:0] OPR_SUM = 4'b0010;
  localparam logic [OPR_W-1:0] OPR_SUB = 4'b0011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_LATCH,
    ST_START,
    ST_WAIT,
    ST_WRITE,
    ST_DONE
  } seq_state_t;

endpackage

// File: rtl/seq_watchdog.sv
// Cycle watchdog for the sequencer WAIT state. Counts enabled cycles from a
// clear; raises a registered, sticky expire once the count reaches limit-1.
// A limit of zero never expires.
module seq_watchdog
  import psdi_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              en,
  input  logic [WDOG_W-1:0] limit,
  output logic              expire
);

  logic [WDOG_W-1:0] count_q, count_d;
  logic              expire_q, expire_d;

  // Next count and expire; expire is registered so the FSM exits on the edge
  // after the limit is reached, giving alu_done that final edge to win.
  always_comb begin
    count_d  = count_q;
    expire_d = expire_q;
    if (clear) begin
      count_d  = '0;
      expire_d = 1'b0;
    end else if (en) begin
      count_d = count_q + WDOG_W'(1);
      if ((limit != '0) && (count_q == (limit - WDOG_W'(1)))) begin
        expire_d = 1'b1;
      end
    end
  end

  // Counter and expire flops
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q  <= '0;
      expire_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      expire_q <= expire_d;
    end
  end

  assign expire = expire_q;

endmodule

// File: rtl/alux_sequencer.sv
// Micro-sequencer running one register-to-register ALUX instruction at a
// time: read operands, latch them, pulse start, wait for done, write back.
// Optional macro ALUX_SEQ_WATCHDOG_EN adds the WAIT-state watchdog and the
// timeout flag; without it WAIT only exits on alu_done and maxclock is unused.
module alux_sequencer
  import psdi_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic [OPR_W-1:0]     instr_opr,
  input  logic [REG_IDX_W-1:0] instr_srcA,
  input  logic [REG_IDX_W-1:0] instr_srcB,
  input  logic [REG_IDX_W-1:0] instr_dst,
  input  logic                 instr_wb,
  input  logic [WDOG_W-1:0]    maxclock,
  output logic [REG_IDX_W-1:0] rb_seloutA,
  output logic [REG_IDX_W-1:0] rb_seloutB,
  output logic                 rb_enrregA,
  output logic                 rb_enrregB,
  input  logic [WIDTH-1:0]     rb_outA,
  input  logic [WIDTH-1:0]     rb_outB,
  output logic                 rb_regwen,
  output logic [REG_IDX_W-1:0] rb_selwreg,
  output logic [1:0]           rb_endwreg,
  output logic [WIDTH-1:0]     rb_in,
  output logic [WIDTH-1:0]     alu_inA,
  output logic [WIDTH-1:0]     alu_inB,
  output logic [OPR_W-1:0]     alu_opr,
  output logic                 alu_start,
  input  logic [WIDTH-1:0]     alu_outAB,
  input  logic                 alu_done,
  output logic [WIDTH-1:0]     result,
  output logic                 result_valid,
  output logic                 timeout,
  output logic                 busy
);

  seq_state_t state_q, state_d;

  logic [OPR_W-1:0]     opr_q, opr_d;
  logic [REG_IDX_W-1:0] dst_q, dst_d;
  logic                 wb_q, wb_d;
  logic [REG_IDX_W-1:0] sel_a_q, sel_a_d;
  logic [REG_IDX_W-1:0] sel_b_q, sel_b_d;
  logic                 rd_en_q, rd_en_d;
  logic [WIDTH-1:0]     opa_q, opa_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic                 start_q, start_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 regwen_q, regwen_d;
  logic [REG_IDX_W-1:0] selwreg_q, selwreg_d;
  logic [WIDTH-1:0]     rb_in_q, rb_in_d;
  logic                 result_valid_q, result_valid_d;
  logic                 timeout_q, timeout_d;
  logic                 busy_q, busy_d;
  logic                 ready_q, ready_d;

  logic                 expire;

`ifdef ALUX_SEQ_WATCHDOG_EN
  logic [WDOG_W-1:0] maxclock_q, maxclock_d;

  // Watchdog runs only in WAIT and is cleared everywhere else
  seq_watchdog u_watchdog (
    .clock  (clock),
    .reset  (reset),
    .clear  (state_q != ST_WAIT),
    .en     (state_q == ST_WAIT),
    .limit  (maxclock_q),
    .expire (expire)
  );

  // Watchdog limit captured with the instruction
  always_comb begin
    maxclock_d = maxclock_q;
    if ((state_q == ST_IDLE) && instr_valid) begin
      maxclock_d = maxclock;
    end
  end

  // Watchdog limit flop
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      maxclock_q <= '0;
    end else begin
      maxclock_q <= maxclock_d;
    end
  end
`else
  logic unused_maxclock;

  assign expire         = 1'b0;
  assign unused_maxclock = ^maxclock;
`endif

  // Next-state and registered-output logic; every strobe is set on the edge
  // that enters the state it belongs to, so it is high for that state only.
  always_comb begin
    state_d        = state_q;
    opr_d          = opr_q;
    dst_d          = dst_q;
    wb_d           = wb_q;
    sel_a_d        = sel_a_q;
    sel_b_d        = sel_b_q;
    rd_en_d        = 1'b0;
    opa_d          = opa_q;
    opb_d          = opb_q;
    start_d        = 1'b0;
    result_d       = result_q;
    regwen_d       = 1'b0;
    selwreg_d      = selwreg_q;
    rb_in_d        = rb_in_q;
    result_valid_d = 1'b0;
    timeout_d      = timeout_q;
    busy_d         = busy_q;
    ready_d        = ready_q;

    unique case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          state_d   = ST_READ;
          opr_d     = instr_opr;
          dst_d     = instr_dst;
          wb_d      = instr_wb;
          sel_a_d   = instr_srcA;
          sel_b_d   = instr_srcB;
          rd_en_d   = 1'b1;
          timeout_d = 1'b0;
          busy_d    = 1'b1;
          ready_d   = 1'b0;
        end
      end
      ST_READ: begin
        state_d = ST_LATCH;
      end
      ST_LATCH: begin
        // Operands are held locally, so dst may alias either source
        state_d = ST_START;
        opa_d   = rb_outA;
        opb_d   = rb_outB;
        start_d = 1'b1;
      end
      ST_START: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (alu_done) begin
          state_d  = ST_WRITE;
          result_d = alu_outAB;
          if (wb_q) begin
            regwen_d  = 1'b1;
            selwreg_d = dst_q;
            rb_in_d   = alu_outAB;
          end
        end else if (expire) begin
          state_d   = ST_WRITE;
          timeout_d = 1'b1;
        end
      end
      ST_WRITE: begin
        state_d        = ST_DONE;
        result_valid_d = 1'b1;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        ready_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  // Sequencer state and registered outputs; reset aborts any instruction
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      opr_q          <= '0;
      dst_q          <= '0;
      wb_q           <= 1'b0;
      sel_a_q        <= '0;
      sel_b_q        <= '0;
      rd_en_q        <= 1'b0;
      opa_q          <= '0;
      opb_q          <= '0;
      start_q        <= 1'b0;
      result_q       <= '0;
      regwen_q       <= 1'b0;
      selwreg_q      <= '0;
      rb_in_q        <= '0;
      result_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
      busy_q         <= 1'b0;
      ready_q        <= 1'b1;
    end else begin
      state_q        <= state_d;
      opr_q          <= opr_d;
      dst_q          <= dst_d;
      wb_q           <= wb_d;
      sel_a_q        <= sel_a_d;
      sel_b_q        <= sel_b_d;
      rd_en_q        <= rd_en_d;
      opa_q          <= opa_d;
      opb_q          <= opb_d;
      start_q        <= start_d;
      result_q       <= result_d;
      regwen_q       <= regwen_d;
      selwreg_q      <= selwreg_d;
      rb_in_q        <= rb_in_d;
      result_valid_q <= result_valid_d;
      timeout_q      <= timeout_d;
      busy_q         <= busy_d;
      ready_q        <= ready_d;
    end
  end

  assign instr_ready  = ready_q;
  assign busy         = busy_q;
  assign rb_seloutA   = sel_a_q;
  assign rb_seloutB   = sel_b_q;
  assign rb_enrregA   = rd_en_q;
  assign rb_enrregB   = rd_en_q;
  assign rb_regwen    = regwen_q;
  assign rb_selwreg   = selwreg_q;
  assign rb_endwreg   = ENDW_FULL;
  assign rb_in        = rb_in_q;
  assign alu_inA      = opa_q;
  assign alu_inB      = opb_q;
  assign alu_opr      = opr_q;
  assign alu_start    = start_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign timeout      = timeout_q;

endmodule

// File: tb/tb_alux_sequencer.sv
// Directed bench for alux_sequencer with a small register-bank and ALUX
// model around it. Timeout cases depend on ALUX_SEQ_WATCHDOG_EN.
module tb_alux_sequencer;

  logic        clock;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  instr_opr;
  logic [3:0]  instr_srcA;
  logic [3:0]  instr_srcB;
  logic [3:0]  instr_dst;
  logic        instr_wb;
  logic [5:0]  maxclock;
  logic [3:0]  rb_seloutA;
  logic [3:0]  rb_seloutB;
  logic        rb_enrregA;
  logic        rb_enrregB;
  logic [63:0] rb_outA;
  logic [63:0] rb_outB;
  logic        rb_regwen;
  logic [3:0]  rb_selwreg;
  logic [1:0]  rb_endwreg;
  logic [63:0] rb_in;
  logic [63:0] alu_inA;
  logic [63:0] alu_inB;
  logic [3:0]  alu_opr;
  logic        alu_start;
  logic [63:0] alu_outAB;
  logic        alu_done;
  logic [63:0] result;
  logic        result_valid;
  logic        timeout;
  logic        busy;

  logic [63:0] regs [16];
  logic        pre_we;
  logic [3:0]  pre_idx;
  logic [63:0] pre_data;
  int          alu_lat;

  int n_checks;
  int n_errors;

  alux_sequencer #(.WIDTH(64)) dut (
    .clock        (clock),
    .reset        (reset),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_opr    (instr_opr),
    .instr_srcA   (instr_srcA),
    .instr_srcB   (instr_srcB),
    .instr_dst    (instr_dst),
    .instr_wb     (instr_wb),
    .maxclock     (maxclock),
    .rb_seloutA   (rb_seloutA),
    .rb_seloutB   (rb_seloutB),
    .rb_enrregA   (rb_enrregA),
    .rb_enrregB   (rb_enrregB),
    .rb_outA      (rb_outA),
    .rb_outB      (rb_outB),
    .rb_regwen    (rb_regwen),
    .rb_selwreg   (rb_selwreg),
    .rb_endwreg   (rb_endwreg),
    .rb_in        (rb_in),
    .alu_inA      (alu_inA),
    .alu_inB      (alu_inB),
    .alu_opr      (alu_opr),
    .alu_start    (alu_start),
    .alu_outAB    (alu_outAB),
    .alu_done     (alu_done),
    .result       (result),
    .result_valid (result_valid),
    .timeout      (timeout),
    .busy         (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Register bank: registered reads, bench preload port, DUT write port
  always @(posedge clock) begin
    if (rb_enrregA) rb_outA <= regs[rb_seloutA];
    if (rb_enrregB) rb_outB <= regs[rb_seloutB];
    if (pre_we) regs[pre_idx] <= pre_data;
    else if (rb_regwen) regs[rb_selwreg] <= rb_in;
  end

  function automatic logic [63:0] alu_model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    case (op)
      4'd0:    return a;
      4'd1:    return b;
      4'd2:    return a + b;
      4'd3:    return a - b;
      default: return 64'd0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [3:0] idx, input logic [63:0] val);
    pre_we   = 1'b1;
    pre_idx  = idx;
    pre_data = val;
    tick();
    pre_we = 1'b0;
  endtask

  // ALUX model: done raised alu_lat cycles after start is seen (<0: never)
  initial begin
    alu_done  = 1'b0;
    alu_outAB = '0;
    forever begin
      tick();
      if (alu_start && reset && alu_lat >= 0) begin
        repeat (alu_lat) tick();
        alu_done  = 1'b1;
        alu_outAB = alu_model(alu_opr, alu_inA, alu_inB);
        tick();
        alu_done  = 1'b0;
      end
    end
  end

  // Issue one instruction from IDLE and follow it to result_valid
  task automatic run_instr(input logic [3:0] opr, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] d, input logic wb, input logic [5:0] mc,
                           output int lat, output int st, output int nwr,
                           output logic [3:0] wsel, output logic [63:0] wdata,
                           output logic rd_ok, output logic to_acc);
    instr_opr   = opr;
    instr_srcA  = a;
    instr_srcB  = b;
    instr_dst   = d;
    instr_wb    = wb;
    maxclock    = mc;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    rd_ok  = rb_enrregA && rb_enrregB && (rb_seloutA == a) && (rb_seloutB == b);
    to_acc = timeout;
    lat = -1; st = -1; nwr = 0; wsel = '0; wdata = '0;
    for (int t = 1; t <= 80 && lat < 0; t++) begin
      tick();
      if (alu_start && st < 0) st = t;
      if (rb_regwen) begin
        nwr++;
        wsel  = rb_selwreg;
        wdata = rb_in;
      end
      if (result_valid) lat = t;
    end
    tick();
  endtask

  initial begin
    int          lat, st, nwr, bad;
    logic [3:0]  wsel;
    logic [63:0] wdata;
    logic        rd_ok, to_acc;

    n_checks = 0; n_errors = 0;
    reset = 1'b0; instr_valid = 1'b0; instr_opr = '0; instr_srcA = '0;
    instr_srcB = '0; instr_dst = '0; instr_wb = 1'b0; maxclock = '0;
    pre_we = 1'b0; pre_idx = '0; pre_data = '0; alu_lat = -1;
    rb_outA = '0; rb_outB = '0;
    for (int i = 0; i < 16; i++) regs[i] = '0;

    repeat (3) tick();
    check("rst_ready",   instr_ready, 1);
    check("rst_busy",    busy, 0);
    check("rst_strobes", {rb_regwen, rb_enrregA, rb_enrregB, alu_start, result_valid}, 0);
    check("rst_timeout", timeout, 0);
    check("rst_result",  result, 0);
    check("rst_ops",     {alu_inA, alu_inB}, 0);
    check("rst_sel",     {rb_seloutA, rb_seloutB, rb_selwreg}, 0);
    check("rst_rbin",    rb_in, 0);
    check("rst_endw",    rb_endwreg, 2'b00);
    reset = 1'b1;
    tick();

    // Basic sum: r7 = r3 + r5
    preload(4'd3, 64'h10);
    preload(4'd5, 64'h22);
    alu_lat = 1;
    run_instr(4'd2, 4'd3, 4'd5, 4'd7, 1'b1, 6'd0, lat, st, nwr, wsel, wdata, rd_ok, to_acc);
    check("sum_read",    rd_ok, 1);
    check("sum_start_t", st, 2);
    check("sum_lat",     lat, 5);
    check("sum_nwr",     nwr, 1);
    check("sum_wsel",    wsel, 7);
    check("sum_wdata",   wdata, 64'h32);
    check("sum_result",  result, 64'h32);
    check("sum_r7",      regs[7], 64'h32);
    check("sum_opr",     alu_opr, 4'd2);
    check("sum_idle",    {instr_ready, busy}, 2'b10);

    // Aliasing: r2 = r2 - r2
    preload(4'd2, 64'h5);
    run_instr(4'd3, 4'd2, 4'd2, 4'd2, 1'b1, 6'd0, lat, st, nwr, wsel, wdata, rd_ok, to_acc);
    check("alias_nwr",    nwr, 1);
    check("alias_r2",     regs[2], 64'h0);
    check("alias_result", result, 64'h0);

`ifdef ALUX_SEQ_WATCHDOG_EN
    // Timeout: ALUX never finishes, limit 4
    alu_lat = -1;
    run_instr(4'd2, 4'd3, 4'd5, 4'd9, 1'b1, 6'd4, lat, st, nwr, wsel, wdata, rd_ok, to_acc);
    check("to_lat",    lat, 9);
    check("to_flag",   timeout, 1);
    check("to_nwr",    nwr, 0);
    check("to_result", result, 64'h0);
    check("to_r9",     regs[9], 64'h0);
    alu_lat = 1;
    run_instr(4'd2, 4'd3, 4'd5, 4'd7, 1'b1, 6'd0, lat, st, nwr, wsel, wdata, rd_ok, to_acc);
    check("to_clear",  to_acc, 0);
    check("to_after",  result, 64'h32);
`else
    // Without the watchdog maxclock has no effect: a late done still completes
    alu_lat = 7;
    run_instr(4'd2, 4'd3, 4'd5, 4'd9, 1'b1, 6'd4, lat, st, nwr, wsel, wdata, rd_ok, to_acc);
    check("nowd_lat",  lat, 11);
    check("nowd_flag", timeout, 0);
    check("nowd_r9",   regs[9], 64'h32);
`endif

    // Done on the same edge the watchdog would end WAIT: done wins
    preload(4'd9, 64'h0);
    alu_lat = 5;
    run_instr(4'd2, 4'd3, 4'd5, 4'd9, 1'b1, 6'd4, lat, st, nwr, wsel, wdata, rd_ok, to_acc);
    check("exp_lat",  lat, 9);
    check("exp_flag", timeout, 0);
    check("exp_nwr",  nwr, 1);
    check("exp_r9",   regs[9], 64'h32);

    // Handshake: instr_valid held high across a wb=0 instruction
    alu_lat = 2;
    instr_opr = 4'd0; instr_srcA = 4'd3; instr_srcB = 4'd5; instr_dst = 4'd8;
    instr_wb = 1'b0; maxclock = 6'd0; instr_valid = 1'b1;
    tick();
    bad = instr_ready ? 1 : 0;
    nwr = 0; lat = -1;
    for (int t = 1; t <= 80 && lat < 0; t++) begin
      tick();
      if (instr_ready) bad++;
      if (rb_regwen) nwr++;
      if (result_valid) lat = t;
    end
    check("hs_lat",      lat, 6);
    check("hs_ready_lo", bad, 0);
    check("hs_nwr",      nwr, 0);
    instr_opr = 4'd1; instr_dst = 4'd9; instr_wb = 1'b1;
    preload(4'd9, 64'h0);
    check("hs_ready_hi", {instr_ready, busy, rb_enrregA}, 3'b100);
    tick();
    check("hs_accept",   {instr_ready, busy, rb_enrregA}, 3'b011);
    check("hs_selA",     rb_seloutA, 4'd3);
    instr_valid = 1'b0;
    nwr = 0; lat = -1; wdata = '0;
    for (int t = 1; t <= 80 && lat < 0; t++) begin
      tick();
      if (rb_regwen) begin nwr++; wdata = rb_in; end
      if (result_valid) lat = t;
    end
    tick();
    check("hs2_lat",   lat, 6);
    check("hs2_wdata", wdata, 64'h22);
    check("hs2_r9",    regs[9], 64'h22);

    // Mid-operation reset while in WAIT
    preload(4'd12, 64'hAA);
    alu_lat = -1;
    instr_opr = 4'd2; instr_srcA = 4'd3; instr_srcB = 4'd5; instr_dst = 4'd12;
    instr_wb = 1'b1; maxclock = 6'd0; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    repeat (4) tick();
    check("mr_busy_pre", busy, 1);
    check("mr_ops_pre",  alu_inA, 64'h10);
    #2 reset = 1'b0;
    #1;
    check("mr_busy",    busy, 0);
    check("mr_ready",   instr_ready, 1);
    check("mr_strobes", {rb_regwen, rb_enrregA, alu_start, result_valid, timeout}, 0);
    check("mr_data",    {alu_inA, result, rb_in}, 0);
    check("mr_sel",     {rb_seloutA, rb_seloutB, rb_selwreg, alu_opr}, 0);
    bad = 0;
    for (int t = 0; t < 3; t++) begin
      tick();
      if (rb_regwen || result_valid) bad++;
    end
    reset = 1'b1;
    for (int t = 0; t < 4; t++) begin
      tick();
      if (rb_regwen || result_valid) bad++;
    end
    check("mr_nowrite", bad, 0);
    check("mr_r12",     regs[12], 64'hAA);
    check("mr_release", {instr_ready, busy}, 2'b10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
